// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter for the picorv32 native memory bus.
// Master 0 (CPU) and master 1 (DMA/debug loader) share one slave port.
// A grant covers exactly one transaction; a watchdog force-completes any
// transaction the slave never acknowledges and records its address.
//
// Handshake: a master raises valid and holds it (with addr/wdata/wstrb stable)
// until its ready pulses for one cycle; rdata is meaningful only while ready
// is high. Dropping valid before ready abandons the transaction silently.
module mem_arbiter #(
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_valid,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,
    output logic [1:0]  grant,
    output logic        err,
    output logic [31:0] err_addr
);

    // Counter must hold TIMEOUT; keep at least one bit when the watchdog is off.
    localparam int            CW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);
    localparam bit            WD_EN   = (TIMEOUT != 0);

    // State encoding doubles as the one-hot grant output.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } state_t;

    state_t        state_q, state_d;
    logic          last_q, last_d;   // index of the master granted most recently
    logic [CW-1:0] cnt_q;
    logic          timeout;
    logic          done;

    // Watchdog fires only when the slave has not answered in the final cycle.
    assign timeout = WD_EN && (state_q != IDLE) && (cnt_q == CNT_MAX) && !s_ready;
    assign done    = s_ready || timeout;
    assign err     = timeout;
    assign grant   = state_q;

    // Next-state, arbitration and slave-port routing.
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        s_valid  = 1'b0;
        s_addr   = 32'h0;
        s_wdata  = 32'h0;
        s_wstrb  = 4'h0;
        m0_ready = 1'b0;
        m0_rdata = 32'h0;
        m1_ready = 1'b0;
        m1_rdata = 32'h0;
        case (state_q)
            IDLE: begin
                if (m0_valid && m1_valid) begin
                    state_d = last_q ? GNT0 : GNT1;
                end else if (m0_valid) begin
                    state_d = GNT0;
                end else if (m1_valid) begin
                    state_d = GNT1;
                end
            end
            GNT0: begin
                s_valid  = m0_valid && !timeout;
                s_addr   = m0_addr;
                s_wdata  = m0_wdata;
                s_wstrb  = m0_wstrb;
                m0_ready = done;
                m0_rdata = timeout ? 32'hFFFF_FFFF : s_rdata;
                if (done) begin
                    state_d = IDLE;
                    last_d  = 1'b0;
                end else if (!m0_valid) begin
                    state_d = IDLE;   // abort: fairness history untouched
                end
            end
            GNT1: begin
                s_valid  = m1_valid && !timeout;
                s_addr   = m1_addr;
                s_wdata  = m1_wdata;
                s_wstrb  = m1_wstrb;
                m1_ready = done;
                m1_rdata = timeout ? 32'hFFFF_FFFF : s_rdata;
                if (done) begin
                    state_d = IDLE;
                    last_d  = 1'b1;
                end else if (!m1_valid) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, fairness history, watchdog counter and error address registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            last_q   <= 1'b1;
            cnt_q    <= '0;
            err_addr <= 32'h0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            if (state_q == IDLE) begin
                cnt_q <= '0;
            end else if (!s_ready && (cnt_q != CNT_MAX)) begin
                cnt_q <= cnt_q + CW'(1);
            end
            if (timeout) begin
                err_addr <= s_addr;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with TIMEOUT = 8. Inputs change 1 ns after
// each rising edge; outputs are sampled on the falling edge.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_valid, m1_valid;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic        m0_ready, m1_ready;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_valid;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_ready;
    logic [31:0] s_rdata;
    logic [1:0]  grant;
    logic        err;
    logic [31:0] err_addr;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.TIMEOUT(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .m0_valid (m0_valid),
        .m0_addr  (m0_addr),
        .m0_wdata (m0_wdata),
        .m0_wstrb (m0_wstrb),
        .m0_ready (m0_ready),
        .m0_rdata (m0_rdata),
        .m1_valid (m1_valid),
        .m1_addr  (m1_addr),
        .m1_wdata (m1_wdata),
        .m1_wstrb (m1_wstrb),
        .m1_ready (m1_ready),
        .m1_rdata (m1_rdata),
        .s_valid  (s_valid),
        .s_addr   (s_addr),
        .s_wdata  (s_wdata),
        .s_wstrb  (s_wstrb),
        .s_ready  (s_ready),
        .s_rdata  (s_rdata),
        .grant    (grant),
        .err      (err),
        .err_addr (err_addr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL sim_timeout: bench did not reach its summary");
        $fatal(1, "bench time limit exceeded");
    end

    initial begin
        logic [1:0] exp_g [8];
        logic [7:0] exp_r0, exp_r1;
        int r0_n, r1_n, sv_n;
        exp_g  = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
        exp_r0 = 8'b0010_0010;  // bit c = m0_ready expected in cycle c
        exp_r1 = 8'b1000_1000;

        // Reset
        rst_n = 1'b0;
        m0_valid = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
        m1_valid = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
        s_ready = 1'b0; s_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_s_valid", 32'(s_valid), 32'h0);
        chk("rst_m0_ready", 32'(m0_ready), 32'h0);
        chk("rst_m1_ready", 32'(m1_ready), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_err_addr", err_addr, 32'h0);
        chk("rst_s_addr", s_addr, 32'h0);

        // Single master read
        tick();
        rst_n = 1'b1;
        m0_valid = 1'b1; m0_addr = 32'h0000_0010; m0_wstrb = 4'h0;
        @(negedge clk);
        chk("rd_idle_grant", 32'(grant), 32'h0);
        chk("rd_idle_s_valid", 32'(s_valid), 32'h0);
        tick();
        s_ready = 1'b1; s_rdata = 32'h1234_5678;
        @(negedge clk);
        chk("rd_grant", 32'(grant), 32'h1);
        chk("rd_s_valid", 32'(s_valid), 32'h1);
        chk("rd_s_addr", s_addr, 32'h0000_0010);
        chk("rd_m0_ready", 32'(m0_ready), 32'h1);
        chk("rd_m0_rdata", m0_rdata, 32'h1234_5678);
        chk("rd_m1_ready", 32'(m1_ready), 32'h0);
        chk("rd_m1_rdata", m1_rdata, 32'h0);
        tick();
        m0_valid = 1'b0; s_ready = 1'b0; s_rdata = '0;
        @(negedge clk);
        chk("rd_after_grant", 32'(grant), 32'h0);
        chk("rd_after_m0_ready", 32'(m0_ready), 32'h0);

        // Simultaneous requests after a fresh reset: m0 wins the first tie
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        m0_valid = 1'b1; m0_addr = 32'h0000_0100;
        m1_valid = 1'b1; m1_addr = 32'h0000_0200;
        s_ready = 1'b1; s_rdata = 32'h0BAD_F00D;
        r0_n = 0; r1_n = 0;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) tick();
            @(negedge clk);
            chk($sformatf("rr_grant_c%0d", c), 32'(grant), 32'(exp_g[c]));
            chk($sformatf("rr_m0_ready_c%0d", c), 32'(m0_ready), 32'(exp_r0[c]));
            chk($sformatf("rr_m1_ready_c%0d", c), 32'(m1_ready), 32'(exp_r1[c]));
            if (exp_g[c] == 2'b01) chk("rr_s_addr_m0", s_addr, 32'h0000_0100);
            if (exp_g[c] == 2'b10) chk("rr_s_addr_m1", s_addr, 32'h0000_0200);
            if (exp_r0[c]) chk("rr_m0_rdata", m0_rdata, 32'h0BAD_F00D);
            if (m0_ready) r0_n++;
            if (m1_ready) r1_n++;
        end
        chk("rr_m0_count", 32'(r0_n), 32'd2);
        chk("rr_m1_count", 32'(r1_n), 32'd2);
        tick();
        m0_valid = 1'b0; m1_valid = 1'b0; s_ready = 1'b0; s_rdata = '0;
        @(negedge clk);
        chk("rr_end_grant", 32'(grant), 32'h0);

        // Watchdog: m1 write, slave never acks
        tick();
        m1_valid = 1'b1; m1_addr = 32'h5000_0004; m1_wdata = 32'hA5A5_5A5A; m1_wstrb = 4'hF;
        @(negedge clk);
        chk("wd_idle_grant", 32'(grant), 32'h0);
        sv_n = 0;
        for (int k = 0; k <= 8; k++) begin
            tick();
            @(negedge clk);
            if (s_valid) sv_n++;
            if (k == 0) begin
                chk("wd_s_wstrb", 32'(s_wstrb), 32'hF);
                chk("wd_s_wdata", s_wdata, 32'hA5A5_5A5A);
            end
            if (k < 8) begin
                chk($sformatf("wd_m1_ready_k%0d", k), 32'(m1_ready), 32'h0);
                chk($sformatf("wd_err_k%0d", k), 32'(err), 32'h0);
            end else begin
                chk("wd_grant", 32'(grant), 32'h2);
                chk("wd_s_valid", 32'(s_valid), 32'h0);
                chk("wd_m1_ready", 32'(m1_ready), 32'h1);
                chk("wd_m1_rdata", m1_rdata, 32'hFFFF_FFFF);
                chk("wd_err", 32'(err), 32'h1);
            end
        end
        chk("wd_s_valid_cycles", 32'(sv_n), 32'd8);
        tick();
        m1_valid = 1'b0; m1_wstrb = 4'h0;
        @(negedge clk);
        chk("wd_after_grant", 32'(grant), 32'h0);
        chk("wd_after_err", 32'(err), 32'h0);
        chk("wd_err_addr", err_addr, 32'h5000_0004);

        // Ack in the final watchdog cycle: slave wins
        tick();
        m0_valid = 1'b1; m0_addr = 32'h0000_0020;
        @(negedge clk);
        for (int k = 0; k <= 8; k++) begin
            tick();
            if (k == 8) begin
                s_ready = 1'b1; s_rdata = 32'hCAFE_F00D;
            end
            @(negedge clk);
            if (k < 8) begin
                chk($sformatf("late_m0_ready_k%0d", k), 32'(m0_ready), 32'h0);
            end else begin
                chk("late_grant", 32'(grant), 32'h1);
                chk("late_m0_ready", 32'(m0_ready), 32'h1);
                chk("late_m0_rdata", m0_rdata, 32'hCAFE_F00D);
                chk("late_err", 32'(err), 32'h0);
            end
        end
        tick();
        m0_valid = 1'b0; s_ready = 1'b0; s_rdata = '0;
        @(negedge clk);
        chk("late_grant_idle", 32'(grant), 32'h0);
        chk("late_err_addr", err_addr, 32'h5000_0004);

        // Abort: m0 drops valid in its third grant cycle (m0 was granted last)
        tick();
        m0_valid = 1'b1;
        @(negedge clk);
        tick();
        @(negedge clk);
        chk("ab_s_valid_k0", 32'(s_valid), 32'h1);
        tick();
        @(negedge clk);
        chk("ab_s_valid_k1", 32'(s_valid), 32'h1);
        tick();
        m0_valid = 1'b0;
        @(negedge clk);
        chk("ab_s_valid_drop", 32'(s_valid), 32'h0);
        chk("ab_m0_ready_drop", 32'(m0_ready), 32'h0);
        chk("ab_grant_drop", 32'(grant), 32'h1);
        tick();
        m0_valid = 1'b1; m1_valid = 1'b1;
        @(negedge clk);
        chk("ab_idle_grant", 32'(grant), 32'h0);
        chk("ab_idle_m0_ready", 32'(m0_ready), 32'h0);
        tick();
        @(negedge clk);
        chk("ab_tie_grant", 32'(grant), 32'h2);

        // Reset mid-grant with the slave stalled
        tick();
        rst_n = 1'b0;
        @(negedge clk);
        chk("mr_grant_during", 32'(grant), 32'h2);
        chk("mr_m1_ready_during", 32'(m1_ready), 32'h0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("mr_grant", 32'(grant), 32'h0);
        chk("mr_m0_ready", 32'(m0_ready), 32'h0);
        chk("mr_m1_ready", 32'(m1_ready), 32'h0);
        chk("mr_s_valid", 32'(s_valid), 32'h0);
        chk("mr_err_addr", err_addr, 32'h0);
        tick();
        @(negedge clk);
        chk("mr_tie_grant", 32'(grant), 32'h1);
        tick();
        m0_valid = 1'b0; m1_valid = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
